// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver for the universal shifter's serial output.
// Optional even-parity checking is enabled by defining SHIFT_DESER_PARITY_EN.
module shift_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dir,
  input  logic             shift_en,
  input  logic             serial_in,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ack,
  output logic             busy,
  output logic             overrun
`ifdef SHIFT_DESER_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);
`ifdef SHIFT_DESER_PARITY_EN
  localparam logic [CW-1:0] C_PAR  = CW'(WIDTH);
`endif

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_sr;
  logic [CW-1:0]    r_cnt;
  logic             r_dir;
  logic [WIDTH-1:0] r_out;
  logic             r_out_valid;
  logic             r_overrun;
`ifdef SHIFT_DESER_PARITY_EN
  logic             r_parity_err;
`endif

  logic [WIDTH-1:0] w_sr_shift;
  logic [WIDTH-1:0] w_first_sr;

  assign w_sr_shift = r_dir ? {serial_in, r_sr[WIDTH-1:1]} : {r_sr[WIDTH-2:0], serial_in};
  // Register image when a restart in DONE also carries the new frame's first bit.
  assign w_first_sr = dir ? {serial_in, {(WIDTH-1){1'b0}}} : {{(WIDTH-1){1'b0}}, serial_in};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_sr        <= '0;
      r_cnt       <= '0;
      r_dir       <= 1'b0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef SHIFT_DESER_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= SHIFT;
            r_dir   <= dir;
            r_sr    <= '0;
            r_cnt   <= '0;
          end
        end
        SHIFT: begin
          if (shift_en) begin
`ifdef SHIFT_DESER_PARITY_EN
            if (r_cnt == C_PAR) begin
              r_out        <= r_sr;
              r_parity_err <= ^{r_sr, serial_in};
              r_out_valid  <= 1'b1;
              r_state      <= DONE;
            end else begin
              r_sr  <= w_sr_shift;
              r_cnt <= r_cnt + C_ONE;
            end
`else
            if (r_cnt == C_LAST) begin
              r_out       <= w_sr_shift;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_sr  <= w_sr_shift;
              r_cnt <= r_cnt + C_ONE;
            end
`endif
          end
        end
        DONE: begin
          if (out_ack) begin
            r_out_valid <= 1'b0;
`ifdef SHIFT_DESER_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            if (start) begin
              r_state <= SHIFT;
              r_dir   <= dir;
              r_sr    <= shift_en ? w_first_sr : '0;
              r_cnt   <= shift_en ? C_ONE : '0;
            end else begin
              r_state <= IDLE;
            end
          end
          // A bit that cannot start a new frame is lost.
          if (shift_en && !(out_ack && start)) begin
            r_overrun <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;
  assign busy      = (r_state != IDLE);
`ifdef SHIFT_DESER_PARITY_EN
  assign parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_shift_deserializer.sv
// Scoreboard bench for shift_deserializer: stimulus pushes expected words,
// a negedge monitor pops and compares on each new out_valid.
module tb_shift_deserializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         dir = 1'b0;
  logic         shift_en = 1'b0;
  logic         serial_in = 1'b0;
  logic [W-1:0] out;
  logic         out_valid;
  logic         out_ack = 1'b0;
  logic         busy;
  logic         overrun;
`ifdef SHIFT_DESER_PARITY_EN
  logic         parity_err;
`endif

  typedef struct {
    logic [W-1:0] word;
    logic         perr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  logic mon_prev = 1'b0;

  shift_deserializer #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .dir(dir),
    .shift_en(shift_en),
    .serial_in(serial_in),
    .out(out),
    .out_valid(out_valid),
    .out_ack(out_ack),
    .busy(busy),
    .overrun(overrun)
`ifdef SHIFT_DESER_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  // Monitor: every new word on out_valid must match the oldest expectation.
  always @(negedge clk) begin
    if (out_valid && !mon_prev) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL word_unexpected: got out=%h with no word expected", out);
      end else begin
        exp_t e;
        logic perr_act;
        e = exp_q.pop_front();
`ifdef SHIFT_DESER_PARITY_EN
        perr_act = parity_err;
`else
        perr_act = 1'b0;
`endif
        if (out !== e.word || perr_act !== e.perr) begin
          n_fail++;
          $display("FAIL word: out=%h perr=%b, expected out=%h perr=%b", out, perr_act, e.word, e.perr);
        end else begin
          $display("word ok: out=%h perr=%b", out, perr_act);
        end
      end
    end
    mon_prev = out_valid;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("check %s: %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    shift_en = 1'b1;
    serial_in = b;
    tick();
    shift_en = 1'b0;
    serial_in = 1'b0;
  endtask

  task automatic do_start(input logic d);
    start = 1'b1;
    dir = d;
    tick();
    start = 1'b0;
  endtask

  task automatic do_ack();
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    chk("ack_clears_valid", {31'd0, out_valid}, 32'd0);
  endtask

  // Full frame: start, WIDTH bits (optional gap), parity bit when enabled.
  task automatic run_frame(input logic [W-1:0] word, input logic d,
                           input int gap_idx, input int gap_len, input logic pflip);
    exp_t e;
    e.word = word;
`ifdef SHIFT_DESER_PARITY_EN
    e.perr = pflip;
`else
    e.perr = 1'b0;
`endif
    exp_q.push_back(e);
    do_start(d);
    chk("busy_in_frame", {31'd0, busy}, 32'd1);
    for (int i = 0; i < W; i++) begin
      if (i == gap_idx) begin
        for (int g = 0; g < gap_len; g++) tick();
      end
      send_bit(d ? word[i] : word[W-1-i]);
    end
`ifdef SHIFT_DESER_PARITY_EN
    send_bit((^word) ^ pflip);
`endif
    chk("latency_valid", {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    repeat (3) tick();
    chk("rst_out", {24'd0, out}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
`ifdef SHIFT_DESER_PARITY_EN
    chk("rst_parity_err", {31'd0, parity_err}, 32'd0);
`endif
    reset = 1'b1;
    tick();

    // Bits in IDLE and ack in IDLE are ignored.
    send_bit(1'b1);
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_overrun", {31'd0, overrun}, 32'd0);

    // MSB-first 0xA5
    run_frame(8'hA5, 1'b0, -1, 0, 1'b0);
    chk("done_busy", {31'd0, busy}, 32'd1);
    do_ack();
    chk("idle_after_ack", {31'd0, busy}, 32'd0);
    chk("out_retained", {24'd0, out}, 32'h0000_00A5);

    // LSB-first words
    run_frame(8'hA5, 1'b1, -1, 0, 1'b0);
    do_ack();
    run_frame(8'h03, 1'b1, -1, 0, 1'b0);
    do_ack();

    // Gap of 3 idle cycles between bits 4 and 5
    run_frame(8'h3C, 1'b0, 4, 3, 1'b0);
    do_ack();

    // Overrun while 0xFF pending
    run_frame(8'hFF, 1'b0, -1, 0, 1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    chk("overrun_set", {31'd0, overrun}, 32'd1);
    chk("overrun_out_held", {24'd0, out}, 32'h0000_00FF);
    chk("overrun_valid_held", {31'd0, out_valid}, 32'd1);
    do_ack();
    chk("overrun_sticky_ack", {31'd0, overrun}, 32'd1);
    run_frame(8'h96, 1'b1, -1, 0, 1'b0);
    do_ack();
    chk("overrun_sticky_frame", {31'd0, overrun}, 32'd1);

    // Reset in the middle of 0x81
    do_start(1'b0);
    send_bit(1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    reset = 1'b0;
    tick();
    chk("midrst_out", {24'd0, out}, 32'd0);
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_overrun", {31'd0, overrun}, 32'd0);
    reset = 1'b1;
    tick();
    run_frame(8'h7E, 1'b0, -1, 0, 1'b0);
    do_ack();

    // Back-to-back restart carrying the first bit of the next frame
    run_frame(8'h5A, 1'b0, -1, 0, 1'b0);
    begin
      exp_t e;
      e.word = 8'h80;
      e.perr = 1'b0;
      exp_q.push_back(e);
    end
    out_ack = 1'b1;
    start = 1'b1;
    dir = 1'b0;
    shift_en = 1'b1;
    serial_in = 1'b1;
    tick();
    out_ack = 1'b0;
    start = 1'b0;
    shift_en = 1'b0;
    serial_in = 1'b0;
    chk("b2b_valid_low", {31'd0, out_valid}, 32'd0);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 7; i++) send_bit(1'b0);
`ifdef SHIFT_DESER_PARITY_EN
    send_bit(1'b1);
`endif
    chk("b2b_latency", {31'd0, out_valid}, 32'd1);
    chk("b2b_overrun", {31'd0, overrun}, 32'd0);
    do_ack();

`ifdef SHIFT_DESER_PARITY_EN
    run_frame(8'hA5, 1'b0, -1, 0, 1'b0);
    do_ack();
    chk("perr_cleared", {31'd0, parity_err}, 32'd0);
    run_frame(8'hA5, 1'b0, -1, 0, 1'b1);
    do_ack();
    chk("perr_cleared2", {31'd0, parity_err}, 32'd0);
`endif

    repeat (2) tick();
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
